mem_write_checker: RTL and testbench

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

---
 rtl/mem_write_checker.sv | 177 +++++++++++++++++
 tb/tb_mem_write_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Data-memory write checker: compares monitored writes against a loaded table of
// expected (addr, data) entries and reports pass, data-mismatch fail or timeout.
module mem_write_checker #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000,
   parameter int ORDERED = 1,
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int TMO_W  = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [IDX_W-1:0]  load_idx,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CNT_W-1:0]  num_entries,
   input  logic              start,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_write_data,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_code,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [DATA_W-1:0] fail_data,
   output logic [CNT_W-1:0]  matched_count,
   output logic [TMO_W-1:0]  cycle_count
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t            state_q, state_d;
   logic [1:0]        rst_sync_q, rst_sync_d;
   logic              rst_n;
   logic [ADDR_W-1:0] entry_addr_q [DEPTH];
   logic [ADDR_W-1:0] entry_addr_d [DEPTH];
   logic [DATA_W-1:0] entry_data_q [DEPTH];
   logic [DATA_W-1:0] entry_data_d [DEPTH];
   logic [DEPTH-1:0]  matched_q, matched_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [CNT_W-1:0]  matched_count_q, matched_count_d;
   logic [TMO_W-1:0]  cycle_count_q, cycle_count_d;
   logic [1:0]        fail_code_q, fail_code_d;
   logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;

   logic [DEPTH-1:0]  cand, dhit;
   logic [IDX_W-1:0]  hit_idx, cand_idx;
   logic              hit, mismatch, done, tmo;
   logic [CNT_W-1:0]  cnt_nx;
   logic [TMO_W-1:0]  cyc_nx;

   // Assert asynchronously, release two edges later so the first active edge is clean.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= '0;
      else        rst_sync_q <= rst_sync_d;
   end
   assign rst_n = rst_sync_q[1];

   // In ordered mode matched_count doubles as the order pointer.
   always_comb begin
      cand     = '0;
      dhit     = '0;
      hit_idx  = '0;
      cand_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cand[i] = mem_write && (CNT_W'(i) < num_q) && !matched_q[i]
                   && (entry_addr_q[i] == dmem_addr)
                   && (ORDERED == 0 || CNT_W'(i) == matched_count_q);
         dhit[i] = cand[i] && (entry_data_q[i] == dmem_write_data);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (dhit[i]) hit_idx  = IDX_W'(i);
         if (cand[i]) cand_idx = IDX_W'(i);
      end
      hit      = |dhit;
      mismatch = (|cand) && !hit;
      cnt_nx   = matched_count_q + CNT_W'(hit);
      done     = cnt_nx >= num_q;
      cyc_nx   = (cycle_count_q == TMO_W'(TIMEOUT)) ? cycle_count_q
                                                    : cycle_count_q + TMO_W'(1);
      tmo      = cyc_nx == TMO_W'(TIMEOUT);
   end

   // A completing match beats both mismatch-free timeout on the same edge.
   always_comb begin
      state_d = state_q;
      if (start) state_d = S_RUN;
      else if (state_q == S_RUN) begin
         if (done)          state_d = S_PASS;
         else if (mismatch) state_d = S_FAIL;
         else if (tmo)      state_d = S_FAIL;
      end
   end

   always_comb begin
      entry_addr_d    = entry_addr_q;
      entry_data_d    = entry_data_q;
      matched_d       = matched_q;
      num_d           = num_q;
      matched_count_d = matched_count_q;
      cycle_count_d   = cycle_count_q;
      fail_code_d     = fail_code_q;
      fail_idx_d      = fail_idx_q;
      fail_data_d     = fail_data_q;
      if (start) begin
         matched_d       = '0;
         matched_count_d = '0;
         cycle_count_d   = '0;
         fail_code_d     = 2'd0;
         fail_idx_d      = '0;
         fail_data_d     = '0;
         num_d = (num_entries > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_entries;
      end else if (state_q == S_RUN) begin
         cycle_count_d = cyc_nx;
         if (hit) begin
            matched_d[hit_idx] = 1'b1;
            matched_count_d    = cnt_nx;
         end
         if (!done) begin
            if (mismatch) begin
               fail_code_d = 2'd1;
               fail_idx_d  = cand_idx;
               fail_data_d = dmem_write_data;
            end else if (tmo) begin
               fail_code_d = 2'd2;
            end
         end
      end
      if (state_q != S_RUN && load_en && int'(load_idx) < DEPTH) begin
         entry_addr_d[load_idx] = load_addr;
         entry_data_d[load_idx] = load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         entry_addr_q    <= '{default: '0};
         entry_data_q    <= '{default: '0};
         matched_q       <= '0;
         num_q           <= '0;
         matched_count_q <= '0;
         cycle_count_q   <= '0;
         fail_code_q     <= 2'd0;
         fail_idx_q      <= '0;
         fail_data_q     <= '0;
      end else begin
         state_q         <= state_d;
         entry_addr_q    <= entry_addr_d;
         entry_data_q    <= entry_data_d;
         matched_q       <= matched_d;
         num_q           <= num_d;
         matched_count_q <= matched_count_d;
         cycle_count_q   <= cycle_count_d;
         fail_code_q     <= fail_code_d;
         fail_idx_q      <= fail_idx_d;
         fail_data_q     <= fail_data_d;
      end
   end

   always_comb begin
      busy = (state_q == S_RUN);
      pass = (state_q == S_PASS);
      fail = (state_q == S_FAIL);
   end

   assign fail_code     = fail_code_q;
   assign fail_idx      = fail_idx_q;
   assign fail_data     = fail_data_q;
   assign matched_count = matched_count_q;
   assign cycle_count   = cycle_count_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: an ordered and an unordered instance
// share stimulus; status is compared as {busy,pass,fail,code,matched,cycles}.
module tb_mem_write_checker;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_en = 1'b0;
   logic [1:0]  load_idx = '0;
   logic [31:0] load_addr = '0, load_data = '0;
   logic [2:0]  num_entries = '0;
   logic        start = 1'b0, mem_write = 1'b0;
   logic [31:0] dmem_addr = '0, dmem_write_data = '0;

   logic        o_busy, o_pass, o_fail, u_busy, u_pass, u_fail;
   logic [1:0]  o_code, u_code, o_fidx, u_fidx;
   logic [31:0] o_fdata, u_fdata;
   logic [2:0]  o_mc, u_mc;
   logic [4:0]  o_cyc, u_cyc;
   logic [12:0] o_st, u_st, exp;
   int          checks = 0, errors = 0;

   assign o_st = {o_busy, o_pass, o_fail, o_code, o_mc, o_cyc};
   assign u_st = {u_busy, u_pass, u_fail, u_code, u_mc, u_cyc};

   always #5 clk = ~clk;

   mem_write_checker #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .TIMEOUT(20), .ORDERED(1)) dut_o (
      .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
      .load_data(load_data), .num_entries(num_entries), .start(start), .mem_write(mem_write),
      .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data), .busy(o_busy), .pass(o_pass),
      .fail(o_fail), .fail_code(o_code), .fail_idx(o_fidx), .fail_data(o_fdata),
      .matched_count(o_mc), .cycle_count(o_cyc));

   mem_write_checker #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .TIMEOUT(20), .ORDERED(0)) dut_u (
      .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
      .load_data(load_data), .num_entries(num_entries), .start(start), .mem_write(mem_write),
      .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data), .busy(u_busy), .pass(u_pass),
      .fail(u_fail), .fail_code(u_code), .fail_idx(u_fidx), .fail_data(u_fdata),
      .matched_count(u_mc), .cycle_count(u_cyc));

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
      load_en = 1'b1; load_idx = i; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic do_start(input logic [2:0] n);
      num_entries = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_write = 1'b1; dmem_addr = a; dmem_write_data = d;
      @(negedge clk);
      mem_write = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      idle(2);
      checks++; if (o_st !== 13'd0 || u_st !== 13'd0) begin errors++;
         $display("FAIL reset_status: got %h/%h expected 0", o_st, u_st); end
      checks++; if ({o_fidx, o_fdata, u_fidx, u_fdata} !== '0) begin errors++;
         $display("FAIL reset_fail_fields: got %h %h %h %h expected 0", o_fidx, o_fdata, u_fidx, u_fdata); end
      reset = 1'b1;
      idle(3);
   endtask

   task automatic test_scenario1();
      load(2'd0, 32'h84, 32'd7);
      do_start(3'd1);
      wr(32'h80, 32'd3);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd1};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s1_ignore: got %h/%h expected %h", o_st, u_st, exp); end
      wr(32'h84, 32'd7);
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd1, 5'd2};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s1_pass: got %h/%h expected %h", o_st, u_st, exp); end
      idle(3);
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s1_sticky: got %h/%h expected %h", o_st, u_st, exp); end
   endtask

   task automatic test_scenario2();
      do_start(3'd1);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s2_restart: got %h/%h expected %h", o_st, u_st, exp); end
      wr(32'h84, 32'd5);
      exp = {1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 5'd1};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s2_fail: got %h/%h expected %h", o_st, u_st, exp); end
      checks++; if (o_fidx !== 2'd0 || o_fdata !== 32'd5 || u_fidx !== 2'd0 || u_fdata !== 32'd5) begin errors++;
         $display("FAIL s2_fail_info: got %0d,%0d/%0d,%0d expected 0,5", o_fidx, o_fdata, u_fidx, u_fdata); end
   endtask

   task automatic test_start_ignore();
      num_entries = 3'd1; start = 1'b1;
      mem_write = 1'b1; dmem_addr = 32'h84; dmem_write_data = 32'd7;
      @(negedge clk);
      start = 1'b0; mem_write = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0};
      checks++; if (o_st !== exp || o_fdata !== 32'd0) begin errors++;
         $display("FAIL start_clears: got %h,%h expected %h,0", o_st, o_fdata, exp); end
      idle(1);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd1};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL start_write_ignored: got %h/%h expected %h", o_st, u_st, exp); end
      wr(32'h84, 32'd7);
      checks++; if (o_pass !== 1'b1 || u_pass !== 1'b1) begin errors++;
         $display("FAIL start_then_match: got %b/%b expected 1", o_pass, u_pass); end
   endtask

   task automatic test_order_timeout();
      load(2'd0, 32'h80, 32'd1);
      load(2'd1, 32'h84, 32'd2);
      do_start(3'd2);
      wr(32'h84, 32'd2);
      wr(32'h80, 32'd1);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 5'd2};
      checks++; if (o_st !== exp) begin errors++;
         $display("FAIL s3_ordered_partial: got %h expected %h", o_st, exp); end
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd2};
      checks++; if (u_st !== exp) begin errors++;
         $display("FAIL s4_unordered_pass: got %h expected %h", u_st, exp); end
      idle(17);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 5'd19};
      checks++; if (o_st !== exp) begin errors++;
         $display("FAIL s3_before_timeout: got %h expected %h", o_st, exp); end
      idle(1);
      exp = {1'b0, 1'b0, 1'b1, 2'd2, 3'd1, 5'd20};
      checks++; if (o_st !== exp) begin errors++;
         $display("FAIL s3_timeout: got %h expected %h", o_st, exp); end
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd2};
      checks++; if (u_st !== exp) begin errors++;
         $display("FAIL s4_held: got %h expected %h", u_st, exp); end
   endtask

   task automatic test_match_on_timeout();
      do_start(3'd2);
      load(2'd0, 32'h80, 32'd9);
      wr(32'h80, 32'd1);
      idle(17);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 5'd19};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s5_run_load_ignored: got %h/%h expected %h", o_st, u_st, exp); end
      wr(32'h84, 32'd2);
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd20};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s5_match_wins: got %h/%h expected %h", o_st, u_st, exp); end
   endtask

   task automatic test_num_zero();
      do_start(3'd0);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL zero_run: got %h/%h expected %h", o_st, u_st, exp); end
      idle(1);
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 5'd1};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL zero_pass: got %h/%h expected %h", o_st, u_st, exp); end
   endtask

   task automatic test_clamp();
      for (int i = 0; i < 4; i++) load(2'(i), 32'h100 + 32'(4 * i), 32'(i + 1));
      do_start(3'd7);
      for (int i = 0; i < 3; i++) wr(32'h100 + 32'(4 * i), 32'(i + 1));
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd3, 5'd3};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL clamp_partial: got %h/%h expected %h", o_st, u_st, exp); end
      wr(32'h10c, 32'd4);
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 5'd4};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL clamp_pass: got %h/%h expected %h", o_st, u_st, exp); end
   endtask

   task automatic test_unordered_select();
      load(2'd0, 32'h200, 32'd1);
      load(2'd1, 32'h204, 32'd5);
      load(2'd2, 32'h200, 32'd2);
      load(2'd3, 32'h208, 32'd3);
      do_start(3'd4);
      wr(32'h200, 32'd2);
      exp = {1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 5'd1};
      checks++; if (o_st !== exp || o_fidx !== 2'd0 || o_fdata !== 32'd2) begin errors++;
         $display("FAIL ord_ptr_mismatch: got %h,%0d,%0d expected %h,0,2", o_st, o_fidx, o_fdata, exp); end
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 5'd1};
      checks++; if (u_st !== exp) begin errors++;
         $display("FAIL unord_data_select: got %h expected %h", u_st, exp); end
      wr(32'h204, 32'd5);
      wr(32'h204, 32'd9);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 5'd3};
      checks++; if (u_st !== exp) begin errors++;
         $display("FAIL unord_matched_ignored: got %h expected %h", u_st, exp); end
      wr(32'h208, 32'd7);
      exp = {1'b0, 1'b0, 1'b1, 2'd1, 3'd2, 5'd4};
      checks++; if (u_st !== exp || u_fidx !== 2'd3 || u_fdata !== 32'd7) begin errors++;
         $display("FAIL unord_mismatch: got %h,%0d,%0d expected %h,3,7", u_st, u_fidx, u_fdata, exp); end
   endtask

   task automatic test_reset_midrun();
      load(2'd0, 32'h84, 32'd7);
      do_start(3'd1);
      idle(3);
      exp = {1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd3};
      checks++; if (o_st !== exp) begin errors++;
         $display("FAIL s6_pre_reset: got %h expected %h", o_st, exp); end
      #2 reset = 1'b0;
      #1;
      checks++; if (o_st !== 13'd0 || u_st !== 13'd0 || o_fdata !== 32'd0 || u_fdata !== 32'd0) begin errors++;
         $display("FAIL s6_async_reset: got %h/%h expected 0", o_st, u_st); end
      @(negedge clk);
      reset = 1'b1;
      idle(3);
      checks++; if (o_st !== 13'd0 || u_st !== 13'd0) begin errors++;
         $display("FAIL s6_no_verdict: got %h/%h expected 0", o_st, u_st); end
      do_start(3'd1);
      wr(32'h0, 32'h0);
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd1, 5'd1};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s6_entries_cleared: got %h/%h expected %h", o_st, u_st, exp); end
      load(2'd0, 32'h84, 32'd7);
      do_start(3'd1);
      wr(32'h80, 32'd3);
      wr(32'h84, 32'd7);
      exp = {1'b0, 1'b1, 1'b0, 2'd0, 3'd1, 5'd2};
      checks++; if (o_st !== exp || u_st !== exp) begin errors++;
         $display("FAIL s6_rerun_pass: got %h/%h expected %h", o_st, u_st, exp); end
   endtask

   initial begin
      test_reset();
      test_scenario1();
      test_scenario2();
      test_start_ignore();
      test_order_timeout();
      test_match_on_timeout();
      test_num_zero();
      test_clamp();
      test_unordered_select();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
